multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameters SHALL be:
- OPCODE_W, default 6, opcode field width.
- ALUOP_W, default 2, ALU operation code width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  OPCODE_W  instruction opcode, sampled from the instruction register.
- mem_ready  in  1  memory completed the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead, MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  write-back data select: 1=MDR.
- RegDst  out  1  destination select: 1=rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU operand A select: 0=PC, 1=rs.
- ALUSrcB  out  2  ALU operand B select: 00=rt, 01=4, 10=signext, 11=signext<<2.
- ALUOp  out  ALUOP_W  00=add, 01=sub, 10=funct.
- PCSource  out  2  next-PC select: 00=ALU, 01=ALUOut, 10=jump target.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- state  out  4  current state, for debug.
REQ-003 Reset SHALL be synchronous and active-high on a single clock, clk; the reset port SHALL be named reset.

Function
REQ-004 States SHALL be: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, ADDIEXE, ADDIWB, BEQ, JMP.
REQ-005 Outputs SHALL decode from the state alone, except the mem_ready-gated signals named in REQ-006 and REQ-009; unlisted outputs SHALL be 0.
REQ-006 FETCH SHALL assert MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSource=00.
- IRWrite and PCWrite SHALL equal mem_ready.
- FETCH SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-007 DECODE SHALL assert ALUSrcA=0, ALUSrcB=11 and ALUOp=00, then branch on opcode:
- 100011 or 101011 -> MEMADR.
- 000000 -> RTEXE.
- 001000 -> ADDIEXE.
- 000100 -> BEQ.
- 000010 -> JMP.
- any other opcode -> FETCH with instr_done=1.
REQ-008 MEMADR SHALL assert ALUSrcA=1, ALUSrcB=10 and ALUOp=00, then go to MEMRD for lw or MEMWR for sw.
REQ-009 Memory-access states SHALL behave as follows:
- MEMRD: IorD=1, MemRead=1; holds until mem_ready=1, then goes to MEMWB.
- MEMWR: IorD=1, MemWrite=1; holds until mem_ready=1, then goes to FETCH with instr_done=mem_ready.
REQ-010 MEMWB SHALL assert RegWrite=1, MemtoReg=1 and RegDst=0, with instr_done=1, then go to FETCH.
REQ-011 R-type states SHALL behave as follows:
- RTEXE: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then RTWB.
- RTWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1, then FETCH.
REQ-012 addi states SHALL behave as follows:
- ADDIEXE: ALUSrcA=1, ALUSrcB=10, ALUOp=00, then ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1, then FETCH.
REQ-013 BEQ SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 and instr_done=1, then go to FETCH.
REQ-014 JMP SHALL assert PCWrite=1, PCSource=10 and instr_done=1, then go to FETCH.
REQ-015 Instruction latencies SHALL be, with mem_ready held at 1:
- lw: 5 cycles.
- sw, R-type, addi: 4 cycles.
- beq, jump: 3 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle.
REQ-016 An unreachable state encoding SHALL transition to FETCH on the next edge, with all outputs 0 in that cycle.

Reset
REQ-017 reset=1 at a rising edge SHALL force state to FETCH, overriding any transition in progress, including a mem_ready wait.
REQ-018 While the state is FETCH after reset, outputs SHALL take the FETCH values of REQ-006, and instr_done SHALL be 0.
REQ-019 No other storage SHALL exist in the block.

Configuration
REQ-020 Macro BNE_EN SHALL control bne support.
- Defined: opcode 000101 SHALL go from DECODE to state BNE, which drives the BEQ outputs plus output BranchNE=1.
- Undefined: port BranchNE SHALL be absent, and 000101 SHALL be handled as an unknown opcode.

Structure
REQ-021 A shared package SHALL hold:
- the opcode constants;
- the state enumeration;
- the ALUOp and ALUSrcB/PCSource encodings.
REQ-022 The block SHALL contain one sub-module, mcu_output_decode: a combinational state-to-outputs map. The next-state logic and state register SHALL stay in the top module.

Verification
REQ-023 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- Reset, then lw (100011) with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 and MemtoReg=1 in cycle 5; instr_done on cycle 5 only.
- R-type (000000) with mem_ready low for 3 FETCH cycles -> IRWrite=0 for 3 cycles, then 1; total latency 7.
- sw (101011) with mem_ready low for 2 MEMWR cycles -> MemWrite=1 for 3 cycles; RegWrite=0 throughout.
- beq (000100) then jump (000010) -> PCWriteCond=1, ALUOp=01 in cycle 3; next instruction PCWrite=1, PCSource=10 in cycle 3.
- Opcode 111111 -> DECODE returns to FETCH with instr_done=1; no RegWrite or MemWrite.
- reset asserted during MEMRD wait -> FETCH next cycle; MemWrite and RegWrite never asserted.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants, states and control bundle for the multicycle control unit.
// Optional bne support is enabled with the BNE_EN macro.
package multicycle_control_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTEXE   = 4'd6,
        RTWB    = 4'd7,
        ADDIEXE = 4'd8,
        ADDIWB  = 4'd9,
        BEQ     = 4'd10,
`ifdef BNE_EN
        BNE     = 4'd12,
`endif
        JMP     = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
`ifdef BNE_EN
        logic       branch_ne;
`endif
    } ctrl_t;

endpackage

// File: rtl/mcu_output_decode.sv
// Combinational map from the current state to the datapath control bundle.
// With BNE_EN defined the BNE state drives the BEQ controls plus branch_ne.
module mcu_output_decode
    import multicycle_control_unit_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    input  logic   bad_op_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            DECODE: begin
                ctrl_o.alu_src_b  = SRCB_IMM_SH;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.instr_done = bad_op_i;
            end
            MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                ctrl_o.i_or_d   = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            MEMWR: begin
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            RTEXE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            RTWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            ADDIEXE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            ADDIWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            BEQ: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
`ifdef BNE_EN
            BNE: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
                ctrl_o.branch_ne     = 1'b1;
            end
`endif
            JMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM: state register and next-state logic.
// Define BNE_EN to add the BNE state and the BranchNE output.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [1:0]          PCSource,
`ifdef BNE_EN
    output logic                BranchNE,
`endif
    output logic                instr_done,
    output logic [3:0]          state
);

    localparam logic [OPCODE_W-1:0] C_RTYPE = OPCODE_W'(OP_RTYPE);
    localparam logic [OPCODE_W-1:0] C_J     = OPCODE_W'(OP_J);
    localparam logic [OPCODE_W-1:0] C_BEQ   = OPCODE_W'(OP_BEQ);
    localparam logic [OPCODE_W-1:0] C_ADDI  = OPCODE_W'(OP_ADDI);
    localparam logic [OPCODE_W-1:0] C_LW    = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] C_SW    = OPCODE_W'(OP_SW);
`ifdef BNE_EN
    localparam logic [OPCODE_W-1:0] C_BNE   = OPCODE_W'(OP_BNE);
`endif

    state_e state_q;
    state_e state_d;
    logic   bad_op;
    ctrl_t  ctrl;

    always_comb begin
        state_d = state_q;
        bad_op  = 1'b0;
        case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (opcode == C_LW || opcode == C_SW) begin
                    state_d = MEMADR;
                end else if (opcode == C_RTYPE) begin
                    state_d = RTEXE;
                end else if (opcode == C_ADDI) begin
                    state_d = ADDIEXE;
                end else if (opcode == C_BEQ) begin
                    state_d = BEQ;
`ifdef BNE_EN
                end else if (opcode == C_BNE) begin
                    state_d = BNE;
`endif
                end else if (opcode == C_J) begin
                    state_d = JMP;
                end else begin
                    state_d = FETCH;
                    bad_op  = 1'b1;
                end
            end
            // opcode is still held in the IR, so it picks load vs store here
            MEMADR:  state_d = (opcode == C_LW) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWR:   if (mem_ready) state_d = FETCH;
            RTEXE:   state_d = RTWB;
            ADDIEXE: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    mcu_output_decode u_dec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .bad_op_i    (bad_op),
        .ctrl_o      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ALUOP_W'(ctrl.alu_op);
    assign PCSource    = ctrl.pc_source;
    assign instr_done  = ctrl.instr_done;
`ifdef BNE_EN
    assign BranchNE    = ctrl.branch_ne;
`endif
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: per-instruction expected state/control sequences plus literal spot checks.
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    localparam logic [5:0] T_RT   = 6'b000000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BAD  = 6'b111111;

    // vector layout: state[20:17] pcw pcwc iord mrd mwr irw m2r rdst rw asa asb[6:5] aop[4:3] pcs[2:1] done
    localparam int B_PCW = 16, B_PCWC = 15, B_MWR = 12, B_IRW = 11;
    localparam int B_M2R = 10, B_RW = 8, B_DONE = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
`ifdef BNE_EN
    logic       BranchNE;
`endif

    int nvec = 0;
    int nerr = 0;
    logic [20:0] log_q[$];

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
`ifdef BNE_EN
        .BranchNE    (BranchNE),
`endif
        .instr_done  (instr_done),
        .state       (state)
    );

    function automatic logic known_op(input logic [5:0] op);
        known_op = (op == T_LW) || (op == T_SW) || (op == T_RT) ||
                   (op == T_ADDI) || (op == T_BEQ) || (op == T_J);
`ifdef BNE_EN
        if (op == T_BNE) known_op = 1'b1;
`endif
    endfunction

    // What each step of an instruction must drive, straight from the control table.
    function automatic logic [20:0] model(input state_e st, input logic mr, input logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done} = '0;
        {asb, aop, pcs} = '0;
        case (st)
            FETCH:   begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            DECODE:  begin asb = 2'b11; done = !known_op(op); end
            MEMADR:  begin asa = 1; asb = 2'b10; end
            MEMRD:   begin iord = 1; mrd = 1; end
            MEMWR:   begin iord = 1; mwr = 1; done = mr; end
            MEMWB:   begin rw = 1; m2r = 1; done = 1; end
            RTEXE:   begin asa = 1; aop = 2'b10; end
            RTWB:    begin rw = 1; rdst = 1; done = 1; end
            ADDIEXE: begin asa = 1; asb = 2'b10; end
            ADDIWB:  begin rw = 1; done = 1; end
            BEQ:     begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            JMP:     begin pcw = 1; pcs = 2'b10; done = 1; end
            default: ;
        endcase
        model = {4'(st), pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa,
                 asb, aop, pcs, done};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cycle(input state_e st, input logic mr, input logic [5:0] op);
        logic [20:0] got, exp;
        mem_ready = mr;
        opcode    = op;
        @(negedge clk);
        exp = model(st, mr, op);
        got = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               instr_done};
        log_q.push_back(got);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL step op=%b st=%0d: got %h expected %h", op, st, got, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        state_e sts[$];
        logic   mrs[$];
        log_q.delete();
        for (int i = 0; i < fw; i++) begin sts.push_back(FETCH); mrs.push_back(0); end
        sts.push_back(FETCH);  mrs.push_back(1);
        sts.push_back(DECODE); mrs.push_back(1);
        case (op)
            T_LW: begin
                sts.push_back(MEMADR); mrs.push_back(1);
                for (int i = 0; i < mw; i++) begin sts.push_back(MEMRD); mrs.push_back(0); end
                sts.push_back(MEMRD); mrs.push_back(1);
                sts.push_back(MEMWB); mrs.push_back(1);
            end
            T_SW: begin
                sts.push_back(MEMADR); mrs.push_back(1);
                for (int i = 0; i < mw; i++) begin sts.push_back(MEMWR); mrs.push_back(0); end
                sts.push_back(MEMWR); mrs.push_back(1);
            end
            T_RT:   begin sts.push_back(RTEXE); mrs.push_back(1); sts.push_back(RTWB); mrs.push_back(1); end
            T_ADDI: begin sts.push_back(ADDIEXE); mrs.push_back(1); sts.push_back(ADDIWB); mrs.push_back(1); end
            T_BEQ:  begin sts.push_back(BEQ); mrs.push_back(1); end
            T_J:    begin sts.push_back(JMP); mrs.push_back(1); end
            default: ;
        endcase
        for (int i = 0; i < sts.size(); i++) cycle(sts[i], mrs[i], op);
    endtask

    function automatic int first_done();
        first_done = -1;
        for (int i = log_q.size() - 1; i >= 0; i--)
            if (log_q[i][B_DONE]) first_done = i + 1;
    endfunction

    function automatic int count_bit(input int b);
        count_bit = 0;
        foreach (log_q[i]) count_bit += int'(log_q[i][b]);
    endfunction

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        opcode = T_RT;
        @(posedge clk);
        @(posedge clk);
        #1;
        cycle(FETCH, 1'b0, T_RT);
        chk("reset_state", int'(state), int'(FETCH));
        chk("reset_done", int'(instr_done), 0);
        cycle(FETCH, 1'b1, T_RT);
        reset = 1'b0;

        run_instr(T_LW, 0, 0);
        chk("lw_latency", first_done(), 5);
        chk("lw_done_count", count_bit(B_DONE), 1);
        chk("lw_c5_regwrite", int'(log_q[4][B_RW]), 1);
        chk("lw_c5_memtoreg", int'(log_q[4][B_M2R]), 1);
        chk("lw_c4_state", int'(log_q[3][20:17]), int'(MEMRD));

        run_instr(T_RT, 3, 0);
        chk("rt_irw_low", count_bit(B_IRW), 1);
        chk("rt_irw_c4", int'(log_q[3][B_IRW]), 1);
        chk("rt_latency", first_done(), 7);

        run_instr(T_SW, 0, 2);
        chk("sw_memwrite_cycles", count_bit(B_MWR), 3);
        chk("sw_regwrite", count_bit(B_RW), 0);
        chk("sw_latency", first_done(), 6);

        run_instr(T_BEQ, 0, 0);
        chk("beq_latency", first_done(), 3);
        chk("beq_pcwc", int'(log_q[2][B_PCWC]), 1);
        chk("beq_aluop", int'(log_q[2][4:3]), 1);

        run_instr(T_J, 0, 0);
        chk("j_pcwrite", int'(log_q[2][B_PCW]), 1);
        chk("j_pcsource", int'(log_q[2][2:1]), 2);

        run_instr(T_ADDI, 0, 0);
        chk("addi_latency", first_done(), 4);

        run_instr(T_BAD, 0, 0);
        chk("bad_latency", first_done(), 2);
        chk("bad_regwrite", count_bit(B_RW), 0);
        chk("bad_memwrite", count_bit(B_MWR), 0);
`ifndef BNE_EN
        run_instr(T_BNE, 1, 0);
        chk("bne_as_unknown", first_done(), 3);
`endif

        log_q.delete();
        cycle(FETCH, 1'b1, T_LW);
        cycle(DECODE, 1'b1, T_LW);
        cycle(MEMADR, 1'b1, T_LW);
        cycle(MEMRD, 1'b0, T_LW);
        reset = 1'b1;
        cycle(MEMRD, 1'b0, T_LW);
        reset = 1'b0;
        cycle(FETCH, 1'b0, T_LW);
        chk("rst_wait_state", int'(log_q[5][20:17]), int'(FETCH));
        chk("rst_wait_done", int'(log_q[5][B_DONE]), 0);
        chk("rst_wait_regwrite", count_bit(B_RW), 0);
        chk("rst_wait_memwrite", count_bit(B_MWR), 0);

        run_instr(T_RT, 0, 0);
        chk("post_rst_rt_latency", first_done(), 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
